// File: rtl/coef_block_buffer_pkg.sv
// Shared MDEC constants/types: block tag, coefficient bank state, bank count.
// Latency: n/a (types only).
// Backpressure: n/a.
package MDEC_Cte;

    // Block number that travels with each coefficient matrix (Y1..Y4, Cr, Cb)
    typedef logic [2:0] MDEC_BLCK;

    // Life cycle of one coefficient bank
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } bank_state_e;

    localparam int COEF_BANK_CNT = 2;
    localparam int COEF_IDX_W    = 6;
    localparam int COEF_VAL_W    = 12;

endpackage

// File: rtl/coef_block_buffer_ram.sv
// coefBankRam: 128x12 simple dual-port RAM, address {bank,idx}, one write port, one read port.
// Latency: read data registered, valid 1 cycle after i_radr.
// Backpressure: none; writes and reads are always accepted.
// Ports: i_clk; i_we/i_wadr/i_wdat write port; i_radr read address; o_rdat registered read data.
module coefBankRam (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [6:0]         i_wadr,
    input  logic signed [11:0] i_wdat,
    input  logic [6:0]         i_radr,
    output logic signed [11:0] o_rdat
);

    // Storage is deliberately not reset; the parent's written masks hide stale contents.
    logic signed [11:0] r_mem [128];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wadr] <= i_wdat;
        end
        o_rdat <= r_mem[i_radr];
    end

endmodule

// File: rtl/coef_block_buffer.sv
// coef_block_buffer: double-buffered 8x8 coefficient store between dequantizer and IDCT.
// Latency: matrixComplete -> o_blockValid 1 cycle; i_readAdr -> o_readValue 1 cycle.
// Backpressure: o_freezePipe (register-derived) when the write bank is still owned by the IDCT.
// Ports: i_clk/i_rst; writer side i_write, i_writeIdx, i_blockNum, i_coefValue, i_matrixComplete,
//        o_freezePipe; reader side o_blockValid, o_blockNum, o_dcOnly, i_readAdr, o_readValue,
//        i_blockDone. Optional macro COEF_BUF_DCONLY_EN enables the o_dcOnly flag logic.
module coef_block_buffer
    import MDEC_Cte::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_write,
    input  logic [5:0]         i_writeIdx,
    input  MDEC_BLCK           i_blockNum,
    input  logic signed [11:0] i_coefValue,
    input  logic               i_matrixComplete,
    output logic               o_freezePipe,
    output logic               o_blockValid,
    output MDEC_BLCK           o_blockNum,
    output logic               o_dcOnly,
    input  logic [5:0]         i_readAdr,
    output logic signed [11:0] o_readValue,
    input  logic               i_blockDone
);

    bank_state_e        r_state [COEF_BANK_CNT];
    logic [63:0]        r_mask  [COEF_BANK_CNT];
    MDEC_BLCK           r_tag   [COEF_BANK_CNT];
    logic               r_wp;
    logic               r_rp;
    logic               r_maskHit;

    bank_state_e        w_stateNxt [COEF_BANK_CNT];
    logic [63:0]        w_maskNxt  [COEF_BANK_CNT];
    MDEC_BLCK           w_tagNxt   [COEF_BANK_CNT];
    logic               w_freeze;
    logic               w_wrAcc;
    logic               w_mcAcc;
    logic               w_doneAcc;
    logic signed [11:0] w_ramRdat;

    // Freeze depends only on registered state, so upstream sees no combinational loop.
    assign w_freeze  = (r_state[r_wp] == READY);
    assign w_wrAcc   = i_write & ~w_freeze;
    assign w_mcAcc   = i_matrixComplete & ~w_freeze;
    assign w_doneAcc = i_blockDone & (r_state[r_rp] == READY);

    // Next-state per bank. Release always targets rp (READY) while writes target wp
    // (never READY when accepted), so the two branches cannot hit the same bank.
    always_comb begin
        for (int b = 0; b < COEF_BANK_CNT; b++) begin
            w_stateNxt[b] = r_state[b];
            w_maskNxt[b]  = r_mask[b];
            w_tagNxt[b]   = r_tag[b];
            if (w_doneAcc && (r_rp == 1'(b))) begin
                w_stateNxt[b] = FREE;
                w_maskNxt[b]  = '0;
            end
            if (r_wp == 1'(b)) begin
                if (w_wrAcc) begin
                    w_maskNxt[b][i_writeIdx] = 1'b1;
                    w_tagNxt[b]              = i_blockNum;
                    if (r_state[b] == FREE) begin
                        w_stateNxt[b] = FILLING;
                    end
                end
                // Completion wins over FILLING; a same-cycle write is already in the mask above.
                if (w_mcAcc) begin
                    w_stateNxt[b] = READY;
                    w_tagNxt[b]   = i_blockNum;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < COEF_BANK_CNT; b++) begin
                r_state[b] <= FREE;
                r_mask[b]  <= '0;
                r_tag[b]   <= '0;
            end
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_maskHit <= 1'b0;
        end else begin
            for (int b = 0; b < COEF_BANK_CNT; b++) begin
                r_state[b] <= w_stateNxt[b];
                r_mask[b]  <= w_maskNxt[b];
                r_tag[b]   <= w_tagNxt[b];
            end
            if (w_mcAcc) begin
                r_wp <= ~r_wp;
            end
            if (w_doneAcc) begin
                r_rp <= ~r_rp;
            end
            // Sampled alongside the RAM read so both refer to the same address/cycle.
            r_maskHit <= r_mask[r_rp][i_readAdr];
        end
    end

    coefBankRam u_ram (
        .i_clk  (i_clk),
        .i_we   (w_wrAcc),
        .i_wadr ({r_wp, i_writeIdx}),
        .i_wdat (i_coefValue),
        .i_radr ({r_rp, i_readAdr}),
        .o_rdat (w_ramRdat)
    );

    assign o_readValue  = r_maskHit ? w_ramRdat : '0;
    assign o_freezePipe = w_freeze;
    assign o_blockValid = (r_state[r_rp] == READY);
    assign o_blockNum   = r_tag[r_rp];

`ifdef COEF_BUF_DCONLY_EN
    // Per-bank "some AC coefficient is nonzero" flag.
    logic r_acNZ    [COEF_BANK_CNT];
    logic w_acNZNxt [COEF_BANK_CNT];

    always_comb begin
        for (int b = 0; b < COEF_BANK_CNT; b++) begin
            w_acNZNxt[b] = r_acNZ[b];
            if (w_doneAcc && (r_rp == 1'(b))) begin
                w_acNZNxt[b] = 1'b0;
            end
            if ((r_wp == 1'(b)) && w_wrAcc && (i_writeIdx != 6'd0) && (i_coefValue != 12'sd0)) begin
                w_acNZNxt[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < COEF_BANK_CNT; b++) begin
                r_acNZ[b] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < COEF_BANK_CNT; b++) begin
                r_acNZ[b] <= w_acNZNxt[b];
            end
        end
    end

    assign o_dcOnly = o_blockValid & ~r_acNZ[r_rp];
`else
    assign o_dcOnly = 1'b0;
`endif

endmodule

// File: doc/coef_block_buffer.md
# coef_block_buffer

Receiving end of the coefficient write stream produced by the pre-IDCT dequantization stage. It collects scattered coefficient writes into one of two 64-entry banks and reads unwritten entries back as zero. It hands each completed matrix to the IDCT through a valid/done handshake. When both banks are owned by the IDCT, it back-pressures the dequantization stage with a freeze signal.

## Interface
Parameters: none.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_write  in  1  coefficient write strobe.
- i_writeIdx  in  6  destination index within the 8x8 matrix.
- i_blockNum  in  MDEC_BLCK  block number travelling with the data.
- i_coefValue  in  12 signed  dequantized coefficient.
- i_matrixComplete  in  1  end of current matrix; may coincide with i_write.
- o_freezePipe  out  1  stall request to the dequantization stage.
- o_blockValid  out  1  the bank at the read pointer holds a complete matrix.
- o_blockNum  out  MDEC_BLCK  block number of that bank.
- o_dcOnly  out  1  the matrix has no nonzero AC term (see Configuration).
- i_readAdr  in  6  IDCT read index.
- o_readValue  out  12 signed  value at i_readAdr from the previous cycle.
- i_blockDone  in  1  IDCT releases the current bank.

## Operation
- Two banks, each with:
  - 64x12 storage;
  - a 64-bit written mask;
  - a MDEC_BLCK tag;
  - state FREE / FILLING / READY.
- Two 1-bit pointers: write pointer wp and read pointer rp.
- Accept rule: a write or a matrixComplete is accepted only when o_freezePipe=0. While frozen, upstream holds its outputs stable, so no write is lost.
- Accepted write:
  - stores mem[wp][idx] and sets mask[wp][idx];
  - latches the tag from i_blockNum;
  - moves a FREE bank to FILLING.
  - A repeated index overwrites the earlier value (last write wins).
- Accepted matrixComplete:
  - a write in the same cycle is stored into bank wp first;
  - bank wp goes to READY and wp toggles;
  - the tag is taken from i_blockNum in that cycle;
  - a matrixComplete on an empty bank produces an all-zero READY matrix.
- o_freezePipe = (state[wp]==READY). It is derived only from registers; there is no combinational path from any input.
- o_blockValid = (state[rp]==READY); o_blockNum = tag[rp].
- Read: o_readValue <= mask[rp][i_readAdr] ? mem[rp][i_readAdr] : 0. The read is registered.
- i_blockDone while o_blockValid=1:
  - state[rp] goes to FREE, mask[rp] clears in one cycle, and rp toggles.
  - i_blockDone while o_blockValid=0 is ignored.
- blockDone and matrixComplete in the same cycle target different banks; both take effect.

## Timing
- Reset values (all asynchronous):
  - outputs: o_freezePipe=0, o_blockValid=0, o_blockNum=0, o_dcOnly=0, o_readValue=0;
  - internal: wp=rp=0, both banks FREE, masks 0.
- Reset mid-matrix discards all contents; storage RAM is not cleared (masks make it invisible).
- Write-to-valid latency: matrixComplete accepted in cycle N gives o_blockValid=1 in cycle N+1.
- Read latency: 1 cycle, i_readAdr in cycle N gives o_readValue in cycle N+1.
- Release: i_blockDone in cycle N drops o_freezePipe (if set) in cycle N+1; first write accepted in N+1.
- Freeze rises in the cycle after the second READY bank is produced.
- Reader and writer never address the same bank, so there is no read-during-write hazard.

## Configuration
- COEF_BUF_DCONLY_EN defined:
  - adds per-bank flag acNZ, set by any accepted write with idx!=0 and value!=0;
  - the flag clears on release and reset;
  - o_dcOnly = o_blockValid & ~acNZ[rp].
- Not defined: no flag logic, and o_dcOnly is tied 0.

## Structure
- Shared package (MDEC_Cte):
  - MDEC_BLCK typedef, already existing;
  - a new bank-state enum (FREE/FILLING/READY);
  - constant COEF_BANK_CNT=2.
- One sub-module, coefBankRam: 128x12 simple dual-port RAM with address {bank,idx}, one write port, one registered read port. Masking stays in the parent.

## Test plan
- Sparse write: reset, then writes idx0=100 and idx63=-5 with matrixComplete on the last write, blockNum=Y1. Required: o_blockValid=1 one cycle later, o_blockNum=Y1; reading idx0/1/63 gives 100/0/-5.
- Overwrite: idx5=7 then idx5=-2048, then complete. Required: read idx5 returns -2048.
- Back-pressure: complete two matrices without releasing. Required: o_freezePipe=1. Upstream holds write idx3=9 for 4 cycles; it is not stored in either full bank. i_blockDone, then the next cycle freeze=0 and the write lands in the freed bank.
- Simultaneous: both banks in use, i_blockDone on bank0 in the same cycle as matrixComplete for bank1. Required: bank0 FREE, bank1 READY, rp=1, no lost matrix.
- Empty block and reset: matrixComplete with no writes gives all 64 reads = 0. Assert i_rst mid-fill; all outputs are 0 immediately and the old data never reappears.
- DC-only with COEF_BUF_DCONLY_EN: writes idx0=50, idx9=0 give o_dcOnly=1. Adding idx9=1 gives o_dcOnly=0. Without the macro, o_dcOnly is always 0.
